tournament_predictor: RTL and testbench

- Parametrised next-generation IF-stage branch predictor: gshare global PHT, per-PC local history with local PHT, and a PC-indexed chooser.
- Predicts direction and target for RISC-V B-type branches and JAL at fetch.
- Trains non-speculatively from the resolved-branch bus.
- After reset, a sweep FSM initialises all tables; the pipeline is stalled meanwhile.

---
 rtl/tournament_predictor_pkg.sv | 35 +++
 rtl/tournament_predictor_sat_ctr2.sv | 21 ++
 rtl/tournament_predictor.sv | 198 +++++++++++++++++++
 tb/tb_tournament_predictor.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tournament_predictor_pkg.sv
// Shared definitions for the tournament branch predictor: ISA opcodes, counter seeds,
// bus widths, sweep/run state encoding and RISC-V immediate extractors.
// Latency: n/a (declarations only). Backpressure: n/a.
package tournament_predictor_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] SC_WEAK_NT = 2'b01;
    localparam logic [1:0] SC_WEAK_T  = 2'b10;

    typedef enum logic {
        PDT_INIT = 1'b0,
        PDT_RUN  = 1'b1
    } pdt_state_e;

    function automatic int pdt_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic inst_addr_t imm_b(input inst_t inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic inst_addr_t imm_j(input inst_t inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/tournament_predictor_sat_ctr2.sv
// pdt_sat_ctr2: next value of a 2-bit saturating counter moved toward taken_i.
// Ports: ctr_i current value, taken_i direction, ctr_o next value. Latency: combinational.
// Backpressure: none.
module pdt_sat_ctr2
    import tournament_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != 2'b11) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != 2'b00) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament predictor (gshare + local history + chooser) for IF-stage B-type/JAL prediction.
// Latency: prediction combinational on if_pc/if_inst; training applied at the next clk edge.
// Backpressure: stallreq holds the pipeline while the post-reset table sweep runs.
// Ports: clk/rst (async active-low); if_pc/if_inst lookup; upd_* resolved-branch training bus;
//        branch_or_not, pdt_* prediction outputs; stallreq.
// Optional PDT_STATS_EN adds stat_lookups / stat_mispredicts counters.
module tournament_predictor
    import tournament_predictor_pkg::*;
#(
    parameter int GHR_BITS        = 12,
    parameter int LHT_IDX_BITS    = 10,
    parameter int LOCAL_BITS      = 4,
    parameter int CHOICE_IDX_BITS = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             if_pc,
    input  logic [31:0]             if_inst,
    input  logic                    upd_valid,
    input  logic [31:0]             upd_pc,
    input  logic                    upd_taken,
    input  logic [GHR_BITS-1:0]     upd_ghr,
    input  logic [LOCAL_BITS-1:0]   upd_lhist,
    input  logic                    upd_g_pred,
    input  logic                    upd_l_pred,
    output logic                    branch_or_not,
    output logic [31:0]             pdt_pc,
    output logic                    pdt_res,
    output logic                    pdt_choice,
    output logic [GHR_BITS-1:0]     pdt_ghr,
    output logic [LOCAL_BITS-1:0]   pdt_lhist,
    output logic                    pdt_g_pred,
    output logic                    pdt_l_pred,
    output logic                    stallreq
`ifdef PDT_STATS_EN
    ,
    output logic [31:0]             stat_lookups,
    output logic [31:0]             stat_mispredicts
`endif
);

    localparam int SWEEP_BITS = pdt_max(pdt_max(GHR_BITS, LHT_IDX_BITS),
                                        pdt_max(CHOICE_IDX_BITS, LOCAL_BITS));
    localparam int GPHT_DEPTH = 1 << GHR_BITS;
    localparam int LPHT_DEPTH = 1 << LOCAL_BITS;
    localparam int LHT_DEPTH  = 1 << LHT_IDX_BITS;
    localparam int CH_DEPTH   = 1 << CHOICE_IDX_BITS;

    pdt_state_e              state_q, state_d;
    logic [SWEEP_BITS-1:0]   sweep_q, sweep_d;
    logic [GHR_BITS-1:0]     ghr_q, ghr_d;

    // Tables are RAM-like: no reset, contents established by the sweep.
    logic [1:0]              gpht_q    [GPHT_DEPTH];
    logic [1:0]              lpht_q    [LPHT_DEPTH];
    logic [1:0]              chooser_q [CH_DEPTH];
    logic [LOCAL_BITS-1:0]   lht_q     [LHT_DEPTH];

    // ---------------- lookup ----------------
    logic                       is_b, is_j, running;
    logic [GHR_BITS-1:0]        l_gidx;
    logic [LHT_IDX_BITS-1:0]    l_lidx;
    logic [CHOICE_IDX_BITS-1:0] l_cidx;
    logic [LOCAL_BITS-1:0]      l_lhist;
    logic                       l_g, l_l, l_c, b_taken;

    assign is_b    = (if_inst[6:0] == OPC_BRANCH);
    assign is_j    = (if_inst[6:0] == OPC_JAL);
    assign running = (state_q == PDT_RUN);
    assign l_gidx  = if_pc[GHR_BITS+1:2] ^ ghr_q;
    assign l_lidx  = if_pc[LHT_IDX_BITS+1:2];
    assign l_cidx  = if_pc[CHOICE_IDX_BITS+1:2];
    assign l_lhist = lht_q[l_lidx];
    assign l_g     = gpht_q[l_gidx][1];
    assign l_l     = lpht_q[l_lhist][1];
    assign l_c     = chooser_q[l_cidx][1];
    assign b_taken = l_c ? l_g : l_l;

    assign branch_or_not = is_b | is_j;
    assign pdt_ghr       = ghr_q;
    assign stallreq      = (state_q == PDT_INIT);

    always_comb begin
        pdt_pc     = if_pc + 32'd4;
        pdt_res    = 1'b0;
        pdt_choice = 1'b0;
        pdt_g_pred = 1'b0;
        pdt_l_pred = 1'b0;
        pdt_lhist  = '0;
        if (!rst) begin
            // While reset is held even the fall-through PC is suppressed.
            pdt_pc = '0;
        end else if (running) begin
            pdt_choice = l_c;
            pdt_g_pred = l_g;
            pdt_l_pred = l_l;
            pdt_lhist  = l_lhist;
            if (is_j) begin
                pdt_res = 1'b1;
                pdt_pc  = if_pc + imm_j(if_inst);
            end else if (is_b) begin
                pdt_res = b_taken;
                if (b_taken) pdt_pc = if_pc + imm_b(if_inst);
            end
        end
    end

    // ---------------- training ----------------
    logic                       upd_en;
    logic [GHR_BITS-1:0]        u_gidx;
    logic [LHT_IDX_BITS-1:0]    u_lidx;
    logic [CHOICE_IDX_BITS-1:0] u_cidx;
    logic [1:0]                 g_cur, g_nxt, lp_cur, lp_nxt, c_cur, c_nxt;
    logic                       unused_upd_pc;

    assign upd_en        = upd_valid & running;
    assign u_gidx        = upd_pc[GHR_BITS+1:2] ^ upd_ghr;
    assign u_lidx        = upd_pc[LHT_IDX_BITS+1:2];
    assign u_cidx        = upd_pc[CHOICE_IDX_BITS+1:2];
    assign g_cur         = gpht_q[u_gidx];
    assign lp_cur        = lpht_q[upd_lhist];
    assign c_cur         = chooser_q[u_cidx];
    assign unused_upd_pc = ^upd_pc;

    pdt_sat_ctr2 u_gpht_ctr (.ctr_i(g_cur),  .taken_i(upd_taken), .ctr_o(g_nxt));
    pdt_sat_ctr2 u_lpht_ctr (.ctr_i(lp_cur), .taken_i(upd_taken), .ctr_o(lp_nxt));
    // Chooser moves toward global when global was the correct one.
    pdt_sat_ctr2 u_ch_ctr   (.ctr_i(c_cur),  .taken_i(upd_g_pred == upd_taken), .ctr_o(c_nxt));

    always_ff @(posedge clk) begin
        if (state_q == PDT_INIT) begin
            // Tables shallower than the sweep are written only while the index fits.
            if ((sweep_q >> GHR_BITS) == '0)        gpht_q[sweep_q[GHR_BITS-1:0]]           <= SC_WEAK_NT;
            if ((sweep_q >> LOCAL_BITS) == '0)      lpht_q[sweep_q[LOCAL_BITS-1:0]]         <= SC_WEAK_NT;
            if ((sweep_q >> CHOICE_IDX_BITS) == '0) chooser_q[sweep_q[CHOICE_IDX_BITS-1:0]] <= SC_WEAK_T;
            if ((sweep_q >> LHT_IDX_BITS) == '0)    lht_q[sweep_q[LHT_IDX_BITS-1:0]]        <= '0;
        end else if (upd_en) begin
            gpht_q[u_gidx]    <= g_nxt;
            lpht_q[upd_lhist] <= lp_nxt;
            lht_q[u_lidx]     <= {upd_lhist[LOCAL_BITS-2:0], upd_taken};
            if (upd_g_pred != upd_l_pred) chooser_q[u_cidx] <= c_nxt;
        end
    end

    // ---------------- sweep / run FSM ----------------
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ghr_d   = ghr_q;
        if (state_q == PDT_INIT) begin
            sweep_d = sweep_q + SWEEP_BITS'(1);
            if (sweep_q == '1) state_d = PDT_RUN;
        end else if (upd_valid) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], upd_taken};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PDT_INIT;
            sweep_q <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ghr_q   <= ghr_d;
        end
    end

`ifdef PDT_STATS_EN
    logic [31:0] lookups_q, lookups_d, mispred_q, mispred_d;
    logic        chosen;

    // Chosen component is judged with the chooser as it stands at training time.
    assign chosen = c_cur[1] ? upd_g_pred : upd_l_pred;

    always_comb begin
        lookups_d = lookups_q;
        mispred_d = mispred_q;
        if (running && is_b)                 lookups_d = lookups_q + 32'd1;
        if (upd_en && (chosen != upd_taken)) mispred_d = mispred_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispred_q;
`endif

endmodule

// File: tb/tb_tournament_predictor.sv
// Self-checking bench for tournament_predictor with small tables (16/8/4/8 entries).
// Latency: n/a. Backpressure: stallreq is observed and counted, never driven.
module tb_tournament_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc, if_inst, upd_pc;
    logic        upd_valid, upd_taken, upd_g_pred, upd_l_pred;
    logic [3:0]  upd_ghr;
    logic [1:0]  upd_lhist;
    logic        branch_or_not, pdt_res, pdt_choice, pdt_g_pred, pdt_l_pred, stallreq;
    logic [31:0] pdt_pc;
    logic [3:0]  pdt_ghr;
    logic [1:0]  pdt_lhist;
`ifdef PDT_STATS_EN
    logic [31:0] stat_lookups, stat_mispredicts;
`endif

    tournament_predictor #(
        .GHR_BITS(4), .LHT_IDX_BITS(3), .LOCAL_BITS(2), .CHOICE_IDX_BITS(3)
    ) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_ghr(upd_ghr), .upd_lhist(upd_lhist),
        .upd_g_pred(upd_g_pred), .upd_l_pred(upd_l_pred),
        .branch_or_not(branch_or_not), .pdt_pc(pdt_pc), .pdt_res(pdt_res),
        .pdt_choice(pdt_choice), .pdt_ghr(pdt_ghr), .pdt_lhist(pdt_lhist),
        .pdt_g_pred(pdt_g_pred), .pdt_l_pred(pdt_l_pred), .stallreq(stallreq)
`ifdef PDT_STATS_EN
        , .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: counters as plain integers 0..3, histories as integers.
    int m_gpht [16];
    int m_lpht [4];
    int m_ch   [8];
    int m_lht  [8];
    int m_ghr;

    function automatic int sat(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic m_init();
        for (int i = 0; i < 16; i++) m_gpht[i] = 1;
        for (int i = 0; i < 4; i++)  m_lpht[i] = 1;
        for (int i = 0; i < 8; i++)  m_ch[i] = 2;
        for (int i = 0; i < 8; i++)  m_lht[i] = 0;
        m_ghr = 0;
    endtask

    task automatic m_update(input logic [31:0] pc, input bit tk, input int gh, input int lh,
                            input bit gp, input bit lp);
        int gi, pi;
        pi = int'((pc / 4) % 16);
        gi = pi ^ gh;
        m_gpht[gi] = sat(m_gpht[gi], tk);
        m_lpht[lh] = sat(m_lpht[lh], tk);
        m_lht[pi % 8] = (lh * 2 + int'(tk)) % 4;
        if (gp != lp) m_ch[pi % 8] = sat(m_ch[pi % 8], gp == tk);
        m_ghr = (m_ghr * 2 + int'(tk)) % 16;
    endtask

    function automatic logic [31:0] enc_b(input logic [31:0] off);
        logic [31:0] o;
        o = off;
        return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] off);
        logic [31:0] o;
        o = off;
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
    endfunction

    task automatic set_upd(input bit v, input logic [31:0] pc, input bit tk, input int gh,
                           input int lh, input bit gp, input bit lp);
        upd_valid  = v;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_ghr    = 4'(gh);
        upd_lhist  = 2'(lh);
        upd_g_pred = gp;
        upd_l_pred = lp;
    endtask

    // Drive an update for one cycle (lookup idle) and mirror it in the model.
    task automatic train(input logic [31:0] pc, input bit tk, input int gh, input int lh,
                         input bit gp, input bit lp);
        @(negedge clk);
        set_upd(1'b1, pc, tk, gh, lh, gp, lp);
        @(posedge clk);
        m_update(pc, tk, gh, lh, gp, lp);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        if_pc = 32'h100;
        if_inst = enc_b(32'h40);
        set_upd(1'b0, 0, 0, 0, 0, 0, 0);
        #12;
        n_cmp++;
        if ({stallreq, pdt_res, pdt_pc, pdt_ghr} !== {1'b1, 1'b0, 32'h0, 4'h0}) begin
            n_err++;
            $display("FAIL reset_outputs got stall=%b res=%b pc=%h ghr=%h want 1 0 0 0",
                     stallreq, pdt_res, pdt_pc, pdt_ghr);
        end
        @(negedge clk);
        rst = 1'b1;
        m_init();
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!stallreq) break;
        end
        n_cmp++;
        if (n !== 16) begin
            n_err++;
            $display("FAIL reset_sweep_len got=%0d cycles want=16", n);
        end
        #2;
        n_cmp++;
        if ({branch_or_not, pdt_res, pdt_choice, pdt_pc} !== {1'b1, 1'b0, 1'b1, 32'h104}) begin
            n_err++;
            $display("FAIL first_lookup got bon=%b res=%b ch=%b pc=%h want 1 0 1 00000104",
                     branch_or_not, pdt_res, pdt_choice, pdt_pc);
        end
    endtask

    task automatic test_saturation();
        // Counter at gidx 0 goes 1->2->3->3->3->2->1; MSB after each step below.
        bit exp_g [6] = '{1, 1, 1, 1, 1, 0};
        for (int k = 0; k < 6; k++) begin
            train(32'h100, (k < 4), 0, 0, 1'b1, 1'b1);
            @(negedge clk);
            if_pc = 32'h100 + 32'(m_ghr * 4);
            if_inst = enc_b(32'h20);
            #1;
            n_cmp++;
            if ({pdt_g_pred, pdt_res} !== {exp_g[k], exp_g[k]}) begin
                n_err++;
                $display("FAIL sat_step%0d got g=%b res=%b want %b", k, pdt_g_pred, pdt_res, exp_g[k]);
            end
        end
    endtask

    task automatic test_jal_other();
        @(negedge clk);
        if_pc = 32'h200;
        if_inst = enc_j(-32'sd8);
        #1;
        n_cmp++;
        if ({branch_or_not, pdt_res, pdt_pc} !== {1'b1, 1'b1, 32'h1F8}) begin
            n_err++;
            $display("FAIL jal got bon=%b res=%b pc=%h want 1 1 000001f8", branch_or_not, pdt_res, pdt_pc);
        end
        if_inst = 32'h00B50533;
        #1;
        n_cmp++;
        if ({branch_or_not, pdt_res, pdt_pc} !== {1'b0, 1'b0, 32'h204}) begin
            n_err++;
            $display("FAIL non_branch got bon=%b res=%b pc=%h want 0 0 00000204", branch_or_not, pdt_res, pdt_pc);
        end
    endtask

    task automatic test_chooser();
        // Rows: g_pred, l_pred, taken; chooser 10->01->00->00->01->10.
        bit rows [5][3] = '{'{0, 1, 1}, '{0, 1, 1}, '{1, 1, 0}, '{1, 0, 1}, '{1, 0, 1}};
        bit exp_c [5]   = '{0, 0, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            train(32'h314, rows[k][2], 3, 2, rows[k][0], rows[k][1]);
            @(negedge clk);
            if_pc = 32'h314;
            if_inst = enc_b(32'h10);
            #1;
            n_cmp++;
            if (pdt_choice !== exp_c[k]) begin
                n_err++;
                $display("FAIL chooser_step%0d got=%b want=%b", k, pdt_choice, exp_c[k]);
            end
        end
    endtask

    task automatic test_random(input int iters);
        logic [31:0] pc, off, e_pc;
        int kind, gi, li, lh;
        bit e_g, e_l, e_c, e_bon, e_res, uv, tk, gp, lp;
        int ugh, ulh;
        logic [31:0] upc;
        for (int it = 0; it < iters; it++) begin
            @(negedge clk);
            pc   = $urandom & 32'hFFFF_FFFC;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                off = 32'(($urandom_range(0, 4095) - 2048) * 2);
                if_inst = enc_b(off);
            end else if (kind == 1) begin
                off = 32'(($urandom_range(0, 1048575) - 524288) * 2);
                if_inst = enc_j(off);
            end else begin
                off = 0;
                if_inst = {$urandom_range(0, 33554431), 7'b0110011};
            end
            if_pc = pc;
            uv  = $urandom_range(0, 1);
            upc = $urandom & 32'h0000_00FC;
            tk  = $urandom_range(0, 1);
            ugh = $urandom_range(0, 15);
            ulh = $urandom_range(0, 3);
            gp  = $urandom_range(0, 1);
            lp  = $urandom_range(0, 1);
            set_upd(uv, upc, tk, ugh, ulh, gp, lp);
            // Expected prediction from the model state before this cycle's training.
            gi = int'((pc / 4) % 16) ^ m_ghr;
            li = int'((pc / 4) % 8);
            lh = m_lht[li];
            e_g = m_gpht[gi] >= 2;
            e_l = m_lpht[lh] >= 2;
            e_c = m_ch[li] >= 2;
            e_bon = (kind != 2);
            if (kind == 0) e_res = e_c ? e_g : e_l;
            else           e_res = (kind == 1);
            e_pc = e_res ? pc + off : pc + 32'd4;
            #1;
            n_cmp++;
            if ({branch_or_not, pdt_res, pdt_pc, pdt_ghr} !== {e_bon, e_res, e_pc, 4'(m_ghr)}) begin
                n_err++;
                $display("FAIL rnd_main it=%0d got bon=%b res=%b pc=%h ghr=%h want %b %b %h %h",
                         it, branch_or_not, pdt_res, pdt_pc, pdt_ghr, e_bon, e_res, e_pc, 4'(m_ghr));
            end
            if (kind != 2) begin
                n_cmp++;
                if ({pdt_choice, pdt_g_pred, pdt_l_pred, pdt_lhist} !== {e_c, e_g, e_l, 2'(lh)}) begin
                    n_err++;
                    $display("FAIL rnd_comp it=%0d got ch=%b g=%b l=%b lh=%0d want %b %b %b %0d",
                             it, pdt_choice, pdt_g_pred, pdt_l_pred, pdt_lhist, e_c, e_g, e_l, lh);
                end
            end
            @(posedge clk);
            if (uv) m_update(upc, tk, ugh, ulh, gp, lp);
        end
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic test_reset_mid_init();
        int n;
        bit stall_ok;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        stall_ok = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            if (!stallreq) stall_ok = 1'b0;
        end
        n_cmp++;
        if (!stall_ok) begin
            n_err++;
            $display("FAIL mid_init_stall got=0 want=1 during first 7 sweep cycles");
        end
        #2;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_init();
        n = 0;
        // Training pulses aimed at entries already swept must be ignored.
        set_upd(1'b1, 32'h100, 1'b1, 0, 0, 1'b0, 1'b1);
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!stallreq) break;
        end
        upd_valid = 1'b0;
        n_cmp++;
        if (n !== 16) begin
            n_err++;
            $display("FAIL mid_init_restart got=%0d cycles want=16", n);
        end
        if_pc = 32'h100;
        if_inst = enc_b(32'h40);
        #1;
        n_cmp++;
        if ({pdt_ghr, pdt_g_pred, pdt_l_pred, pdt_choice, pdt_lhist} !== {4'h0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
            n_err++;
            $display("FAIL init_upd_ignored got ghr=%h g=%b l=%b ch=%b lh=%0d want 0 0 0 1 0",
                     pdt_ghr, pdt_g_pred, pdt_l_pred, pdt_choice, pdt_lhist);
        end
    endtask

    task automatic test_same_cycle_hazard();
        @(negedge clk);
        if_pc = 32'h100;
        if_inst = enc_b(32'h80);
        set_upd(1'b1, 32'h100, 1'b1, 0, 0, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if ({pdt_g_pred, pdt_res, pdt_pc} !== {1'b0, 1'b0, 32'h104}) begin
            n_err++;
            $display("FAIL hazard_old got g=%b res=%b pc=%h want 0 0 00000104", pdt_g_pred, pdt_res, pdt_pc);
        end
        @(posedge clk);
        m_update(32'h100, 1'b1, 0, 0, 1'b1, 1'b1);
        #1;
        upd_valid = 1'b0;
        if_pc = 32'h104;   // gidx stays 0 with the shifted history
        #1;
        n_cmp++;
        if ({pdt_ghr, pdt_g_pred, pdt_res, pdt_pc} !== {4'b0001, 1'b1, 1'b1, 32'h184}) begin
            n_err++;
            $display("FAIL hazard_new got ghr=%b g=%b res=%b pc=%h want 0001 1 1 00000184",
                     pdt_ghr, pdt_g_pred, pdt_res, pdt_pc);
        end
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_jal_other();
        test_chooser();
        test_random(400);
        test_reset_mid_init();
        test_same_cycle_hazard();
        test_random(150);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
